// File: rtl/spidergon_output_arbiter.sv
// Switch allocator for one Spidergon output link: round-robin flit grant across all
// input-port VCs, wormhole lock per downstream VC, credit-based flow control.
module spidergon_output_arbiter #(
    parameter int NUM_OF_INPUTS           = 4,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NODE_BUFFER_WIDTH       = 2 * FLIT_DATA_WIDTH,
    localparam int R       = NUM_OF_INPUTS * NUM_OF_VIRTUAL_CHANNELS,
    localparam int NVC     = NUM_OF_VIRTUAL_CHANNELS,
    localparam int CREDITS = NODE_BUFFER_WIDTH / FLIT_DATA_WIDTH,
    localparam int CW      = $clog2(CREDITS + 1),
    localparam int VW      = (NVC > 1) ? $clog2(NVC) : 1,
    localparam int RW      = (R > 1) ? $clog2(R) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [R-1:0]      req,
    input  logic [R-1:0]      req_tail,
    input  logic [NVC-1:0]    credit_return,
    output logic [R-1:0]      grant,
    output logic              out_valid,
    output logic [VW-1:0]     out_vc,
    output logic [NVC-1:0]    vc_locked,
    output logic [NVC*CW-1:0] credit_cnt,
    output logic              credit_err
);

    logic [RW-1:0]  rr_ptr;
    logic [RW-1:0]  owner [NVC];
    logic [CW-1:0]  cnt   [NVC];
    logic [NVC-1:0] lock;
    logic           err;

    logic [R-1:0]   elig;
    logic [R-1:0]   grant_c;
    logic           found;
    logic [RW-1:0]  gidx;
    logic [VW-1:0]  gvc;
    logic [NVC-1:0] xfer_vc;

    // A locked VC only accepts flits from the requester that opened the packet.
    always_comb begin
        elig = '0;
        for (int k = 0; k < R; k++) begin
            elig[k] = req[k] && (cnt[k % NVC] != '0) &&
                      (!lock[k % NVC] || owner[k % NVC] == RW'(k));
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        grant_c = '0;
        found   = 1'b0;
        gidx    = '0;
        for (int i = 0; i < R; i++) begin
            idx = (int'(rr_ptr) + i) % R;
            if (!found && elig[idx]) begin
                grant_c[idx] = 1'b1;
                gidx         = RW'(idx);
                found        = 1'b1;
            end
        end
        if (reset) begin
            grant_c = '0;
            found   = 1'b0;
        end
    end

    always_comb begin
        gvc     = VW'(int'(gidx) % NVC);
        xfer_vc = '0;
        for (int v = 0; v < NVC; v++) begin
            xfer_vc[v] = found && (gvc == VW'(v));
        end
    end

    assign grant      = grant_c;
    assign out_valid  = found;
    assign out_vc     = found ? gvc : '0;
    assign vc_locked  = lock;
    assign credit_err = err;

    always_comb begin
        credit_cnt = '0;
        for (int v = 0; v < NVC; v++) begin
            credit_cnt[v*CW +: CW] = cnt[v];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            lock   <= '0;
            err    <= 1'b0;
            for (int v = 0; v < NVC; v++) begin
                owner[v] <= '0;
                cnt[v]   <= CW'(CREDITS);
            end
        end else begin
            if (found) begin
                rr_ptr <= RW'((int'(gidx) + 1) % R);
            end
            for (int v = 0; v < NVC; v++) begin
                // Simultaneous send and return cancel out.
                if (xfer_vc[v] && !credit_return[v]) begin
                    cnt[v] <= cnt[v] - 1'b1;
                end else if (credit_return[v] && !xfer_vc[v]) begin
                    if (cnt[v] == CW'(CREDITS)) begin
                        err <= 1'b1;
                    end else begin
                        cnt[v] <= cnt[v] + 1'b1;
                    end
                end
                if (xfer_vc[v]) begin
                    if (req_tail[gidx]) begin
                        lock[v] <= 1'b0;
                    end else if (!lock[v]) begin
                        lock[v]  <= 1'b1;
                        owner[v] <= gidx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spidergon_output_arbiter.sv
// Scoreboard bench: stimulus queues expected (cycle, requester) grants, a negedge
// monitor pops and compares whenever out_valid is seen.
module tb_spidergon_output_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] req_tail;
    logic [1:0] credit_return;
    logic [7:0] grant;
    logic       out_valid;
    logic [0:0] out_vc;
    logic [1:0] vc_locked;
    logic [3:0] credit_cnt;
    logic       credit_err;

    typedef struct {
        int c;
        int k;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    spidergon_output_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_tail      (req_tail),
        .credit_return (credit_return),
        .grant         (grant),
        .out_valid     (out_valid),
        .out_vc        (out_vc),
        .vc_locked     (vc_locked),
        .credit_cnt    (credit_cnt),
        .credit_err    (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_grant cycle=%0d grant=%b required none", cyc, grant);
            end else begin
                exp_t e;
                logic [7:0] eg;
                e  = q.pop_front();
                eg = 8'b1 << e.k;
                if (e.c != cyc || grant != eg || out_vc != 1'(e.k % 2)) begin
                    n_fail++;
                    $display("FAIL grant_seq cycle=%0d grant=%b vc=%0d required cycle=%0d grant=%b vc=%0d",
                             cyc, grant, out_vc, e.c, eg, e.k % 2);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; k >= 0 queues the grant expected in this cycle.
    task automatic drive(input logic [7:0] r, input logic [7:0] t, input logic [1:0] cr, input int k);
        @(posedge clk);
        #1;
        req           = r;
        req_tail      = t;
        credit_return = cr;
        if (k >= 0) q.push_back('{c: cyc, k: k});
    endtask

    initial begin
        reset = 1'b1; req = 8'hff; req_tail = 8'h00; credit_return = 2'b00;
        repeat (2) begin
            drive(8'hff, 8'h00, 2'b00, -1);
            @(negedge clk);
            chk("reset_grant", 32'(grant), 32'h0);
        end
        drive(8'h00, 8'h00, 2'b00, -1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_credit", 32'(credit_cnt), 32'hA);
        chk("rst_lock", 32'(vc_locked), 32'h0);
        chk("rst_err", 32'(credit_err), 32'h0);

        // round-robin across VC0 single-flit requesters
        drive(8'h55, 8'hff, 2'b01, 0);
        drive(8'h55, 8'hff, 2'b01, 2);
        drive(8'h55, 8'hff, 2'b01, 4);
        drive(8'h55, 8'hff, 2'b01, 6);
        drive(8'h55, 8'hff, 2'b01, 0);
        drive(8'h00, 8'h00, 2'b00, -1);
        @(negedge clk);
        chk("xfer_plus_return", 32'(credit_cnt), 32'hA);

        // wormhole lock: 2 owns VC0, 4 waits
        drive(8'h14, 8'h10, 2'b01, 2);
        drive(8'h14, 8'h10, 2'b01, 2);
        @(negedge clk);
        chk("lock_vc0", 32'(vc_locked), 32'h1);
        drive(8'h14, 8'h14, 2'b01, 2);
        drive(8'h10, 8'h10, 2'b01, 4);
        @(negedge clk);
        chk("unlock_vc0", 32'(vc_locked), 32'h0);
        drive(8'h00, 8'h00, 2'b00, -1);

        // VC interleaving while VC0 locked by 0
        drive(8'h03, 8'h02, 2'b01, 0);
        drive(8'h03, 8'h02, 2'b10, 1);
        @(negedge clk);
        chk("lock_owner0", 32'(vc_locked), 32'h1);
        drive(8'h03, 8'h02, 2'b01, 0);
        drive(8'h03, 8'h02, 2'b10, 1);
        drive(8'h03, 8'h03, 2'b01, 0);
        drive(8'h00, 8'h00, 2'b00, -1);
        @(negedge clk);
        chk("interleave_lock", 32'(vc_locked), 32'h0);
        chk("interleave_credit", 32'(credit_cnt), 32'hA);
        chk("interleave_err", 32'(credit_err), 32'h0);

        // credit exhaustion and return latency
        drive(8'h01, 8'h01, 2'b00, 0);
        drive(8'h01, 8'h01, 2'b00, 0);
        drive(8'h01, 8'h01, 2'b00, -1);
        @(negedge clk);
        chk("credit_empty", 32'(credit_cnt), 32'h8);
        drive(8'h01, 8'h01, 2'b01, -1);
        drive(8'h01, 8'h01, 2'b00, 0);
        drive(8'h00, 8'h00, 2'b00, -1);
        @(negedge clk);
        chk("credit_reused", 32'(credit_cnt), 32'h8);
        drive(8'h00, 8'h00, 2'b01, -1);
        drive(8'h00, 8'h00, 2'b01, -1);
        drive(8'h00, 8'h00, 2'b00, -1);
        @(negedge clk);
        chk("credit_restored", 32'(credit_cnt), 32'hA);

        // credit overflow is sticky
        drive(8'h00, 8'h00, 2'b10, -1);
        drive(8'h00, 8'h00, 2'b00, -1);
        @(negedge clk);
        chk("overflow_cnt", 32'(credit_cnt), 32'hA);
        chk("overflow_err", 32'(credit_err), 32'h1);
        drive(8'h00, 8'h00, 2'b00, -1);
        @(negedge clk);
        chk("err_sticky", 32'(credit_err), 32'h1);

        // reset mid-packet
        drive(8'h08, 8'h00, 2'b00, 3);
        drive(8'h00, 8'h00, 2'b00, -1);
        @(negedge clk);
        chk("lock_vc1", 32'(vc_locked), 32'h2);
        chk("credit_vc1", 32'(credit_cnt), 32'h6);
        drive(8'h08, 8'h00, 2'b00, -1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_grant", 32'(grant), 32'h0);
        drive(8'h00, 8'h00, 2'b00, -1);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mid_lock", 32'(vc_locked), 32'h0);
        chk("reset_mid_credit", 32'(credit_cnt), 32'hA);
        chk("reset_mid_err", 32'(credit_err), 32'h0);

        drive(8'h00, 8'h00, 2'b00, -1);
        drive(8'h00, 8'h00, 2'b00, -1);
        @(negedge clk);
        chk("grants_outstanding", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog cycle=%0d required finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spidergon_output_arbiter.md
# spidergon_output_arbiter

Per-output-port switch allocator for a Spidergon router node. It shares one outgoing link (clockwise, counter-clockwise, across or local eject) among all input-port virtual channels that want it. It grants at most one flit per cycle, round-robin, and holds a downstream virtual channel to one requester from head flit to tail flit. It transfers a flit only when the downstream virtual-channel buffer has a free slot, tracked with credit counters.

## Interface
- NUM_OF_INPUTS, 4, input ports competing for this output (local, CW, CCW, across)
- NUM_OF_VIRTUAL_CHANNELS, 2, VCs per port
- FLIT_DATA_WIDTH, 16, flit width in bits
- NODE_BUFFER_WIDTH, 2*FLIT_DATA_WIDTH, downstream VC buffer size in bits
- Derived: R = NUM_OF_INPUTS*NUM_OF_VIRTUAL_CHANNELS requesters; CREDITS = NODE_BUFFER_WIDTH/FLIT_DATA_WIDTH (2); CW = $clog2(CREDITS+1)
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; one clock; all state is sampled on posedge clk
- req  input  R  requester k = i*NUM_OF_VIRTUAL_CHANNELS+v has a flit for downstream VC v (VC preserved across hop)
- req_tail  input  R  the flit presented by requester k is a tail (head+tail = single-flit packet)
- credit_return  input  NUM_OF_VIRTUAL_CHANNELS  downstream freed one slot of VC v this cycle
- grant  output  R  one-hot or zero; flit of requester k transfers this cycle
- out_valid  output  1  |grant
- out_vc  output  $clog2(NUM_OF_VIRTUAL_CHANNELS)  VC of granted flit; 0 when idle
- vc_locked  output  NUM_OF_VIRTUAL_CHANNELS  registered; downstream VC v owned by an in-progress packet
- credit_cnt  output  NUM_OF_VIRTUAL_CHANNELS*CW  registered free-slot count per VC, VC v at [v*CW +: CW]
- credit_err  output  1  sticky; credit_return arrived while that VC's count was CREDITS

## Operation
- Eligibility of requester k, where v = k mod NUM_OF_VIRTUAL_CHANNELS: req[k] && credit_cnt[v] != 0 && (!vc_locked[v] || owner[v] == k).
- Grant: the first eligible k found scanning upward from rr_ptr, wrapping from R-1 to 0. Combinational from registered state plus req/req_tail. Transfer = grant[k] (req[k] is implied).
- rr_ptr update on a transfer: (k+1) mod R. Unchanged when idle.
- Lock, per downstream VC v:
  - Transfer with !req_tail on an unlocked VC: vc_locked[v]=1, owner[v]=k.
  - Transfer with req_tail: vc_locked[v]=0.
  - Single-flit packet (head is tail): VC never locks.
- Other VCs remain arbitrable while one VC is locked; flit-level interleaving across VCs is allowed.
- Credits, per VC:
  - Transfer on v: decrement.
  - credit_return[v]: increment.
  - Both in the same cycle: unchanged.
  - Return with count already CREDITS: count stays at CREDITS, credit_err set.
- credit_err clears only on reset.
- Non-owner requesters on a locked VC get no grant, whatever the rr position.

## Timing
- Reset values: grant=0, out_valid=0, out_vc=0, vc_locked=0, owner=0, rr_ptr=0, every credit_cnt=CREDITS, credit_err=0.
- While reset is high, grant is forced to 0 regardless of req.
- Grant is a zero-latency combinational path. Lock, credit and rr_ptr updates appear the next cycle.
- A credit returned in cycle t is usable for a grant in cycle t+1, not t.
- With CREDITS=2 and no returns, VC v sends at most 2 flits, then stalls.
- Reset asserted mid-packet drops locks and restores full credits. Upstream is reset in the same cycle.
- Requester must hold req stable until granted. Dropping req while owning a lock keeps the lock.

## Test plan
- Reset with req=all-ones during reset -> grant=0; after reset, credit_cnt={2,2}, vc_locked=0, credit_err=0.
- req[0],req[2],req[4],req[6] (all VC0) held, each a single-flit packet, credit_return[0] every cycle -> grants in order 0,2,4,6,0 on consecutive cycles.
- Requester 2 sends head (req_tail=0) on VC0; requester 4 also requests VC0 -> vc_locked[0]=1, owner 2. Requester 4 is never granted until requester 2's tail transfers, then wins the next cycle.
- Requester 1 (VC1) requests while VC0 is locked by requester 0 -> grants alternate between 0 and 1 per round-robin; out_vc tracks each.
- No credit_return; requester 0 sends 3 single-flit packets -> 2 grants, credit_cnt[0]=0, third stalls. A credit_return[0] in cycle t yields a grant in t+1.
- credit_return[1] while credit_cnt[1]=2 -> credit_cnt[1] stays 2, credit_err=1 until reset. Transfer plus return on VC0 in the same cycle -> credit_cnt[0] unchanged.
